insn_fetch_queue: RTL and testbench
===================================

// Module: insn_fetch_queue
// PURPOSE
// - Circular FIFO between the fetch unit and decode_riscv. Buffers fetched
//   instructions with their PC and predictor sideband.
// - Drives the decoder's insn/pc/insn_pred/pht_idx/insn_pred_target inputs
//   from the head entry.
// - Absorbs fetch/decode rate mismatch. Drops all entries on a pipeline flush.
// PARAMETERS
// - LG_DEPTH  3   log2 entry count; depth = 2**LG_DEPTH, must be >= 1
// - PC_W      32  PC / predicted-target width, matches M_WIDTH
// - PHT_W     16  PHT index width, matches LG_PHT_SZ
// PORTS
// - clk              in   1           clock
// - reset            in   1           asynchronous, active-low reset
// - flush            in   1           drop all entries (mispredict / restart)
// - in_valid         in   1           fetch presents an instruction
// - in_ready         out  1           queue can accept
// - in_insn          in   32          raw instruction
// - in_pc            in   PC_W        instruction PC
// - in_pred          in   1           predicted taken
// - in_pht_idx       in   PHT_W       PHT index used for the prediction
// - in_pred_target   in   PC_W        predicted target
// - out_valid        out  1           head entry valid toward decode
// - out_ready        in   1           decode consumes head this cycle
// - out_insn / out_pc / out_pred / out_pht_idx / out_pred_target
//                    out  as in_*     head entry fields
// - occupancy        out  LG_DEPTH+1  number of stored entries
// BEHAVIOUR
// - Storage: 2**LG_DEPTH entries. Head/tail pointers are LG_DEPTH+1 bits; the
//   MSB is a wrap bit.
//   - empty = (head == tail)
//   - full  = low bits equal AND wrap bits differ
// - push = in_valid & in_ready. It writes mem[tail] and increments tail.
// - pop = out_valid & out_ready & !bypass_hit. It increments head.
// - in_ready = !full & !flush. It never depends on out_ready.
//   - Full with a simultaneous pop still refuses the push.
// - out_valid = !empty & !flush. out_* are read combinationally from
//   mem[head]. Contents are don't-care when out_valid=0.
// - Latency: a push in cycle N appears at out_* in cycle N+1 (no bypass).
// - Simultaneous push and pop: both pointers advance; occupancy is unchanged.
// - Wrap: pointers wrap modulo 2**(LG_DEPTH+1) with no bubble at the
//   boundary.
// - occupancy = tail - head, computed modulo 2**(LG_DEPTH+1). It is
//   registered through the pointers, so it is not an extra flop.
// - flush (synchronous, highest priority):
//   - Cycle N: no push is accepted and no pop occurs.
//   - Cycle N+1: head = tail = 0, occupancy = 0, out_valid = 0,
//     in_ready = 1.
// - Reset asserted (asynchronous): head = tail = 0, occupancy = 0,
//   out_valid = 0, in_ready = 1 (0 if flush is high).
//   - Entry storage is not reset.
//   - Reset mid-traffic discards all entries immediately.
// - Back-pressure: while out_ready = 0, out_* hold stable and out_valid stays
//   1 until the entry pops or a flush occurs.
// CONFIGURATION
// - FETCH_QUEUE_BYPASS_EN defined:
//   - When empty & in_valid & !flush, out_valid = 1 and out_* = in_*
//     combinationally (bypass).
//   - If out_ready is also 1, this is a bypass_hit: no write, no pointer
//     change, and 0-cycle latency.
//   - If out_ready is 0, the instruction is pushed normally.
// - FETCH_QUEUE_BYPASS_EN undefined: no bypass; minimum latency 1 cycle;
//   bypass_hit = 0.
// TESTING
// - Reset, then 4 pushes with pc = 0x100, 0x104, 0x108, 0x10c and
//   out_ready = 0 -> occupancy = 4, out_pc = 0x100, in_ready = 1.
// - LG_DEPTH = 3, 8 pushes with no pops -> occupancy = 8, in_ready = 0.
//   - A 9th in_valid with out_ready = 1 is refused; the pop occurs;
//     occupancy = 7 next cycle.
// - Steady push + pop every cycle for 40 cycles, pc incrementing by 4 ->
//   out_pc sequence is strictly +4 across pointer wrap; no loss, no
//   duplication.
// - occupancy = 5, flush pulsed with in_valid = 1 -> that push is dropped.
//   - Next cycle: occupancy = 0, out_valid = 0.
//   - A following push of insn 0x00000013 is seen at out_insn one cycle
//     later.
// - Push insn 0x00c58533 with in_pred = 1, in_pht_idx = 0x2a,
//   in_pred_target = 0x2000 -> identical sideband at the outputs when the
//   entry reaches the head.
// - Empty queue, in_valid = out_ready = 1:
//   - FETCH_QUEUE_BYPASS_EN defined: out_valid = 1 the same cycle,
//     occupancy stays 0.
//   - FETCH_QUEUE_BYPASS_EN undefined: out_valid = 0 that cycle, then 1 the
//     next cycle.

Source files
------------

// File: rtl/insn_fetch_queue.sv
// ============================================================================
// Module   : insn_fetch_queue
// Purpose  : Circular FIFO of fetched instructions (PC + predictor sideband)
//            feeding the decoder from its head entry.
// Options  : FETCH_QUEUE_BYPASS_EN - same-cycle bypass of an empty queue
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module insn_fetch_queue #(
  parameter int LG_DEPTH = 3,
  parameter int PC_W     = 32,
  parameter int PHT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,

  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_insn,
  input  logic [PC_W-1:0]     in_pc,
  input  logic                in_pred,
  input  logic [PHT_W-1:0]    in_pht_idx,
  input  logic [PC_W-1:0]     in_pred_target,

  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_insn,
  output logic [PC_W-1:0]     out_pc,
  output logic                out_pred,
  output logic [PHT_W-1:0]    out_pht_idx,
  output logic [PC_W-1:0]     out_pred_target,

  output logic [LG_DEPTH:0]   occupancy
);

  localparam int c_DEPTH = 1 << LG_DEPTH;

  typedef struct packed {
    logic [31:0]      insn;
    logic [PC_W-1:0]  pc;
    logic             pred;
    logic [PHT_W-1:0] pht_idx;
    logic [PC_W-1:0]  pred_target;
  } entry_t;

  entry_t               r_mem [c_DEPTH];
  logic [LG_DEPTH:0]    r_head;
  logic [LG_DEPTH:0]    r_tail;

  entry_t               w_in_entry;
  entry_t               w_head_entry;
  entry_t               w_out_entry;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_bypass;
  logic                 w_bypass_hit;
  logic                 w_push;
  logic                 w_pop;

  assign w_in_entry = '{insn:        in_insn,
                        pc:          in_pc,
                        pred:        in_pred,
                        pht_idx:     in_pht_idx,
                        pred_target: in_pred_target};

  // The extra MSB on each pointer distinguishes full from empty.
  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[LG_DEPTH-1:0] == r_tail[LG_DEPTH-1:0]) &&
                   (r_head[LG_DEPTH] != r_tail[LG_DEPTH]);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass     = w_empty & in_valid & ~flush;
  assign w_bypass_hit = w_bypass & out_ready;
`else
  assign w_bypass     = 1'b0;
  assign w_bypass_hit = 1'b0;
`endif

  assign in_ready  = ~w_full & ~flush;
  assign out_valid = (~w_empty & ~flush) | w_bypass;

  // A bypassed instruction goes straight to decode and never occupies a slot.
  assign w_push = in_valid & in_ready & ~w_bypass_hit;
  assign w_pop  = out_valid & out_ready & ~w_bypass_hit;

  assign w_head_entry = r_mem[r_head[LG_DEPTH-1:0]];
  assign w_out_entry  = w_bypass ? w_in_entry : w_head_entry;

  assign out_insn        = w_out_entry.insn;
  assign out_pc          = w_out_entry.pc;
  assign out_pred        = w_out_entry.pred;
  assign out_pht_idx     = w_out_entry.pht_idx;
  assign out_pred_target = w_out_entry.pred_target;

  assign occupancy = r_tail - r_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
    end
  end

  // Entry storage carries no reset; validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail[LG_DEPTH-1:0]] <= w_in_entry;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_insn_fetch_queue.sv
// ============================================================================
// Module   : tb_insn_fetch_queue
// Purpose  : Directed self-checking bench for insn_fetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_insn_fetch_queue;

  localparam int LG_DEPTH = 3;
  localparam int PC_W     = 32;
  localparam int PHT_W    = 16;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_insn;
  logic [PC_W-1:0]   in_pc;
  logic              in_pred;
  logic [PHT_W-1:0]  in_pht_idx;
  logic [PC_W-1:0]   in_pred_target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_insn;
  logic [PC_W-1:0]   out_pc;
  logic              out_pred;
  logic [PHT_W-1:0]  out_pht_idx;
  logic [PC_W-1:0]   out_pred_target;
  logic [LG_DEPTH:0] occupancy;

  int n_total = 0;
  int n_pass  = 0;

  insn_fetch_queue #(
    .LG_DEPTH(LG_DEPTH),
    .PC_W    (PC_W),
    .PHT_W   (PHT_W)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_insn        (in_insn),
    .in_pc          (in_pc),
    .in_pred        (in_pred),
    .in_pht_idx     (in_pht_idx),
    .in_pred_target (in_pred_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_insn       (out_insn),
    .out_pc         (out_pc),
    .out_pred       (out_pred),
    .out_pht_idx    (out_pht_idx),
    .out_pred_target(out_pred_target),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Inputs change 1 ns after the edge; checks happen 1 ns after that.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [PC_W-1:0] pc);
    in_valid       = v;
    in_insn        = insn;
    in_pc          = pc;
    in_pred        = 1'b0;
    in_pht_idx     = '0;
    in_pred_target = '0;
  endtask

  int pops;
  logic [PC_W-1:0] exp_pc;

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, '0);

    // Reset state
    step();
    step();
    check("rst_occ", occupancy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    flush = 1'b1;
    #1;
    check("rst_flush_in_ready", in_ready, 0);
    flush = 1'b0;
    #2;
    reset = 1'b1;
    step();

    // Four pushes under back-pressure
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000 + i, 32'h100 + 4 * i);
      step();
    end
    drive(1'b0, 32'h0, '0);
    #1;
    check("bp_occ4", occupancy, 4);
    check("bp_out_pc", out_pc, 32'h100);
    check("bp_in_ready", in_ready, 1);
    check("bp_out_valid", out_valid, 1);
    step();
    check("bp_hold_pc", out_pc, 32'h100);
    check("bp_hold_insn", out_insn, 32'h1000);

    // Fill to full and try a ninth push with a simultaneous pop
    for (int i = 4; i < 8; i++) begin
      drive(1'b1, 32'h1000 + i, 32'h100 + 4 * i);
      step();
    end
    drive(1'b1, 32'hbad, 32'h999);
    out_ready = 1'b1;
    #1;
    check("full_occ8", occupancy, 8);
    check("full_in_ready", in_ready, 0);
    check("full_head_pc", out_pc, 32'h100);
    step();
    drive(1'b0, 32'h0, '0);
    out_ready = 1'b0;
    #1;
    check("full_pop_occ7", occupancy, 7);
    check("full_pop_next_pc", out_pc, 32'h104);

    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      check("drain_pc", out_pc, 32'h104 + 4 * k);
      step();
    end
    out_ready = 1'b0;
    #1;
    check("drain_empty_valid", out_valid, 0);
    check("drain_empty_occ", occupancy, 0);

    // Steady push+pop across pointer wrap
    pops   = 0;
    exp_pc = 32'h400;
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 32'h2000 + k, 32'h400 + 4 * k);
      #1;
      if (out_valid) begin
        check("steady_pc", out_pc, exp_pc);
        exp_pc = exp_pc + 4;
        pops++;
      end
      @(posedge clk);
      #1;
    end
    drive(1'b0, 32'h0, '0);
    for (int k = 0; k < 10 && out_valid; k++) begin
      #1;
      check("steady_tail_pc", out_pc, exp_pc);
      exp_pc = exp_pc + 4;
      pops++;
      step();
    end
    out_ready = 1'b0;
    #1;
    check("steady_pop_count", pops, 40);
    check("steady_drained", out_valid, 0);
    check("steady_occ", occupancy, 0);

    // Flush with a concurrent push
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h3000 + i, 32'h500 + 4 * i);
      step();
    end
    drive(1'b1, 32'hdead, 32'h5ff);
    #1;
    check("pre_flush_occ5", occupancy, 5);
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    check("flush_out_valid", out_valid, 0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, '0);
    #1;
    check("post_flush_occ", occupancy, 0);
    check("post_flush_valid", out_valid, 0);
    check("post_flush_in_ready", in_ready, 1);
    drive(1'b1, 32'h00000013, 32'h800);
    step();
    drive(1'b0, 32'h0, '0);
    #1;
    check("post_flush_insn", out_insn, 32'h00000013);
    check("post_flush_occ1", occupancy, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Predictor sideband travels with its entry
    drive(1'b1, 32'h4000, 32'h600);
    step();
    in_valid       = 1'b1;
    in_insn        = 32'h00c58533;
    in_pc          = 32'h604;
    in_pred        = 1'b1;
    in_pht_idx     = 16'h002a;
    in_pred_target = 32'h2000;
    step();
    drive(1'b0, 32'h0, '0);
    #1;
    check("sb_head_pc", out_pc, 32'h600);
    check("sb_head_pred", out_pred, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    check("sb_insn", out_insn, 32'h00c58533);
    check("sb_pc", out_pc, 32'h604);
    check("sb_pred", out_pred, 1);
    check("sb_pht_idx", out_pht_idx, 16'h002a);
    check("sb_target", out_pred_target, 32'h2000);
    out_ready = 1'b1;
    step();

    // Empty queue, push and pop requested together
    drive(1'b1, 32'h77, 32'h700);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_same_valid", out_valid, 1);
    check("byp_same_pc", out_pc, 32'h700);
`else
    check("byp_same_valid", out_valid, 0);
`endif
    check("byp_same_occ", occupancy, 0);
    step();
    drive(1'b0, 32'h0, '0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_next_valid", out_valid, 0);
    check("byp_next_occ", occupancy, 0);
`else
    check("byp_next_valid", out_valid, 1);
    check("byp_next_pc", out_pc, 32'h700);
    check("byp_next_occ", occupancy, 1);
`endif
    step();
    out_ready = 1'b0;

    // Asynchronous reset mid-traffic
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h5000 + i, 32'h900 + 4 * i);
      step();
    end
    drive(1'b0, 32'h0, '0);
    #1;
    check("pre_arst_occ3", occupancy, 3);
    reset = 1'b0;
    #1;
    check("arst_occ", occupancy, 0);
    check("arst_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    #1;
    reset = 1'b1;
    step();
    check("post_arst_occ", occupancy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
